// File: rtl/mem_filter_pkg.sv
// Shared types, default parameters and width helpers for the filter SRAM sequencer.
package mem_filter_pkg;

    localparam int BUS_SIZE_DEF        = 32;
    localparam int CHUNK_SIZE_DEF      = 128;
    localparam int SRAM_FILTER_NUM_DEF = 4;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        LOAD,
        READY,
        READ
    } mem_filter_ctrl_state_e;

    function automatic int wr_dat_cyc_num(input int chunk_size, input int bus_size);
        return chunk_size / bus_size;
    endfunction

    // A bound of 1 still needs a 1-bit counter so the ports never collapse to zero width.
    function automatic int cnt_width(input int bound);
        return (bound > 1) ? $clog2(bound) : 1;
    endfunction

endpackage

// File: rtl/mem_filter_ctrl_if.sv
// Load stream, memory write bus and read sweep signals of the filter SRAM sequencer.
interface mem_filter_ctrl_if
    import mem_filter_pkg::*;
#(
    parameter int BUS_SIZE        = BUS_SIZE_DEF,
    parameter int CHUNK_SIZE      = CHUNK_SIZE_DEF,
    parameter int SRAM_FILTER_NUM = SRAM_FILTER_NUM_DEF
);

    localparam int WR_DAT_CYC_NUM = wr_dat_cyc_num(CHUNK_SIZE, BUS_SIZE);
    localparam int DW             = cnt_width(WR_DAT_CYC_NUM);
    localparam int CW             = cnt_width(SRAM_FILTER_NUM);

    logic                  load_start_i;
    logic [BUS_SIZE-1:0]   in_sparsemap_i;
    logic [BUS_SIZE*8-1:0] in_nonzero_data_i;
    logic                  in_valid_i;
    logic                  in_ready_o;
    logic [BUS_SIZE-1:0]   mem_wr_sparsemap_o;
    logic [BUS_SIZE*8-1:0] mem_wr_nonzero_data_o;
    logic                  mem_wr_valid_o;
    logic [DW-1:0]         mem_wr_dat_count_o;
    logic [CW-1:0]         mem_wr_chunk_count_o;
    logic                  mem_clr_o;
    logic                  rd_start_i;
    logic                  rd_stall_i;
    logic [DW-1:0]         mem_rd_dat_count_o;
    logic [CW-1:0]         mem_rd_chunk_count_o;
    logic                  rd_valid_o;
    logic                  rd_last_o;
    logic                  load_done_o;
    logic                  rd_done_o;
    logic                  loaded_o;

    modport slave (
        input  load_start_i, in_sparsemap_i, in_nonzero_data_i, in_valid_i,
               rd_start_i, rd_stall_i,
        output in_ready_o, mem_wr_sparsemap_o, mem_wr_nonzero_data_o, mem_wr_valid_o,
               mem_wr_dat_count_o, mem_wr_chunk_count_o, mem_clr_o,
               mem_rd_dat_count_o, mem_rd_chunk_count_o, rd_valid_o, rd_last_o,
               load_done_o, rd_done_o, loaded_o
    );

    modport master (
        output load_start_i, in_sparsemap_i, in_nonzero_data_i, in_valid_i,
               rd_start_i, rd_stall_i,
        input  in_ready_o, mem_wr_sparsemap_o, mem_wr_nonzero_data_o, mem_wr_valid_o,
               mem_wr_dat_count_o, mem_wr_chunk_count_o, mem_clr_o,
               mem_rd_dat_count_o, mem_rd_chunk_count_o, rd_valid_o, rd_last_o,
               load_done_o, rd_done_o, loaded_o
    );

endinterface

// File: rtl/mem_filter_addr_cnt.sv
// Beat/chunk two-level address counter; beats wrap at BEAT_NUM, chunks at CHUNK_NUM.
module mem_filter_addr_cnt
    import mem_filter_pkg::*;
#(
    parameter int BEAT_NUM  = 4,
    parameter int CHUNK_NUM = 4,
    localparam int BW = cnt_width(BEAT_NUM),
    localparam int CW = cnt_width(CHUNK_NUM)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          en_i,
    input  logic          clr_i,
    output logic [BW-1:0] beat_o,
    output logic [CW-1:0] chunk_o,
    output logic          last_o
);

    logic [BW-1:0] beat_q, beat_d;
    logic [CW-1:0] chunk_q, chunk_d;
    logic          beat_max, chunk_max;

    assign beat_max  = (beat_q == BW'(BEAT_NUM - 1));
    assign chunk_max = (chunk_q == CW'(CHUNK_NUM - 1));

    always_comb begin
        beat_d  = beat_q;
        chunk_d = chunk_q;
        if (clr_i) begin
            beat_d  = '0;
            chunk_d = '0;
        end else if (en_i) begin
            if (beat_max) begin
                beat_d  = '0;
                chunk_d = chunk_max ? '0 : chunk_q + 1'b1;
            end else begin
                beat_d = beat_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            beat_q  <= '0;
            chunk_q <= '0;
        end else begin
            beat_q  <= beat_d;
            chunk_q <= chunk_d;
        end
    end

    assign beat_o  = beat_q;
    assign chunk_o = chunk_q;
    assign last_o  = beat_max && chunk_max;

endmodule

// File: rtl/mem_filter_ctrl.sv
// Filter SRAM sequencer: streams a full bank load into memory and replays it as a read sweep.
// Optional one-cycle memory clear before each load when MEM_FILTER_CTRL_CLR_EN is defined.
module mem_filter_ctrl
    import mem_filter_pkg::*;
#(
    parameter int BUS_SIZE        = BUS_SIZE_DEF,
    parameter int CHUNK_SIZE      = CHUNK_SIZE_DEF,
    parameter int SRAM_FILTER_NUM = SRAM_FILTER_NUM_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    mem_filter_ctrl_if.slave  bus
);

    localparam int WR_DAT_CYC_NUM = wr_dat_cyc_num(CHUNK_SIZE, BUS_SIZE);
    localparam int DW             = cnt_width(WR_DAT_CYC_NUM);
    localparam int CW             = cnt_width(SRAM_FILTER_NUM);

`ifdef MEM_FILTER_CTRL_CLR_EN
    localparam mem_filter_ctrl_state_e LOAD_ENTRY = CLEAR;
`else
    localparam mem_filter_ctrl_state_e LOAD_ENTRY = LOAD;
`endif

    mem_filter_ctrl_state_e state_q, state_d;
    logic loaded_q, loaded_d;
    logic load_done_q, load_done_d;
    logic rd_done_q, rd_done_d;

    logic          wr_en, wr_clr, wr_last;
    logic          rd_en, rd_clr, rd_last;
    logic [DW-1:0] wr_beat, rd_beat;
    logic [CW-1:0] wr_chunk, rd_chunk;

    // Counters are held at zero outside their own phase so each load/sweep starts at (0,0).
    assign wr_en  = (state_q == LOAD) && bus.in_valid_i;
    assign wr_clr = (state_q != LOAD);
    assign rd_en  = (state_q == READ) && !bus.rd_stall_i;
    assign rd_clr = (state_q != READ);

    mem_filter_addr_cnt #(
        .BEAT_NUM  (WR_DAT_CYC_NUM),
        .CHUNK_NUM (SRAM_FILTER_NUM)
    ) u_wr_cnt (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .en_i    (wr_en),
        .clr_i   (wr_clr),
        .beat_o  (wr_beat),
        .chunk_o (wr_chunk),
        .last_o  (wr_last)
    );

    mem_filter_addr_cnt #(
        .BEAT_NUM  (WR_DAT_CYC_NUM),
        .CHUNK_NUM (SRAM_FILTER_NUM)
    ) u_rd_cnt (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .en_i    (rd_en),
        .clr_i   (rd_clr),
        .beat_o  (rd_beat),
        .chunk_o (rd_chunk),
        .last_o  (rd_last)
    );

    always_comb begin
        state_d     = state_q;
        loaded_d    = loaded_q;
        load_done_d = 1'b0;
        rd_done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.load_start_i) state_d = LOAD_ENTRY;
            end
            CLEAR: state_d = LOAD;
            LOAD: begin
                if (wr_en && wr_last) begin
                    state_d     = READY;
                    loaded_d    = 1'b1;
                    load_done_d = 1'b1;
                end
            end
            // A reload request takes priority over a read request.
            READY: begin
                if (bus.load_start_i) begin
                    state_d  = LOAD_ENTRY;
                    loaded_d = 1'b0;
                end else if (bus.rd_start_i) begin
                    state_d = READ;
                end
            end
            READ: begin
                if (rd_en && rd_last) begin
                    state_d   = READY;
                    rd_done_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= IDLE;
            loaded_q    <= 1'b0;
            load_done_q <= 1'b0;
            rd_done_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            loaded_q    <= loaded_d;
            load_done_q <= load_done_d;
            rd_done_q   <= rd_done_d;
        end
    end

    assign bus.in_ready_o            = (state_q == LOAD);
    assign bus.mem_wr_sparsemap_o    = bus.in_sparsemap_i;
    assign bus.mem_wr_nonzero_data_o = bus.in_nonzero_data_i;
    assign bus.mem_wr_valid_o        = wr_en;
    assign bus.mem_wr_dat_count_o    = wr_beat;
    assign bus.mem_wr_chunk_count_o  = wr_chunk;
    assign bus.mem_rd_dat_count_o    = rd_beat;
    assign bus.mem_rd_chunk_count_o  = rd_chunk;
    assign bus.rd_valid_o            = (state_q == READ);
    assign bus.rd_last_o             = (state_q == READ) && rd_last;
    assign bus.load_done_o           = load_done_q;
    assign bus.rd_done_o             = rd_done_q;
    assign bus.loaded_o              = loaded_q;

`ifdef MEM_FILTER_CTRL_CLR_EN
    assign bus.mem_clr_o = (state_q == CLEAR);
`else
    assign bus.mem_clr_o = 1'b0;
`endif

endmodule

// File: tb/tb_mem_filter_ctrl.sv
// Scoreboard bench for mem_filter_ctrl: write and read beats are queued when driven and popped by a monitor.
module tb_mem_filter_ctrl;
    import mem_filter_pkg::*;

    localparam int BUS = BUS_SIZE_DEF;

    typedef struct {
        int               chunk;
        int               beat;
        logic [BUS-1:0]   smap;
        logic [BUS*8-1:0] nz;
    } wr_exp_t;

    typedef struct {
        int   chunk;
        int   beat;
        logic last;
    } rd_exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    wr_exp_t wrQ[$];
    rd_exp_t rdQ[$];
    wr_exp_t wrE;
    rd_exp_t rdE;

    always #5 clk = ~clk;

    mem_filter_ctrl_if bus ();

    mem_filter_ctrl dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus)
    );

    // Monitor: every write or read beat the DUT presents must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.mem_wr_valid_o) begin
                checks++;
                if (wrQ.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL wr_unexpected got write at (%0d,%0d) exp no write",
                             bus.mem_wr_chunk_count_o, bus.mem_wr_dat_count_o);
                end else begin
                    wrE = wrQ.pop_front();
                    if (int'(bus.mem_wr_chunk_count_o) !== wrE.chunk || int'(bus.mem_wr_dat_count_o) !== wrE.beat ||
                        bus.mem_wr_sparsemap_o !== wrE.smap || bus.mem_wr_nonzero_data_o !== wrE.nz) begin
                        errors++;
                        $display("[TB] FAIL wr_beat got (%0d,%0d) smap %0h exp (%0d,%0d) smap %0h",
                                 bus.mem_wr_chunk_count_o, bus.mem_wr_dat_count_o, bus.mem_wr_sparsemap_o,
                                 wrE.chunk, wrE.beat, wrE.smap);
                    end
                end
            end
            if (bus.rd_valid_o) begin
                checks++;
                if (rdQ.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL rd_unexpected got read at (%0d,%0d) exp no read",
                             bus.mem_rd_chunk_count_o, bus.mem_rd_dat_count_o);
                end else begin
                    rdE = rdQ.pop_front();
                    if (int'(bus.mem_rd_chunk_count_o) !== rdE.chunk || int'(bus.mem_rd_dat_count_o) !== rdE.beat ||
                        bus.rd_last_o !== rdE.last) begin
                        errors++;
                        $display("[TB] FAIL rd_beat got (%0d,%0d) last %0b exp (%0d,%0d) last %0b",
                                 bus.mem_rd_chunk_count_o, bus.mem_rd_dat_count_o, bus.rd_last_o,
                                 rdE.chunk, rdE.beat, rdE.last);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic loadStart, input logic rdStart);
        bus.load_start_i = loadStart;
        bus.rd_start_i   = rdStart;
        tick();
        bus.load_start_i = 1'b0;
        bus.rd_start_i   = 1'b0;
    endtask

    task automatic waitReady();
        for (int k = 0; k < 5 && bus.in_ready_o !== 1'b1; k++) tick();
        checks++;
        if (bus.in_ready_o !== 1'b1) begin
            errors++;
            $display("[TB] FAIL wait_ready got in_ready %0b exp 1 within 5 cycles", bus.in_ready_o);
        end
    endtask

    // Drives 16 beats; with gap set, in_valid_i is low on every other cycle starting with the first.
    task automatic driveBeats(input bit gap);
        int sent;
        int cyc;
        sent = 0;
        cyc  = 0;
        waitReady();
        while (sent < 16) begin
            if (gap && (cyc % 2 == 0)) begin
                bus.in_valid_i     = 1'b0;
                bus.in_sparsemap_i = 32'hDEAD_BEEF;
            end else begin
                bus.in_valid_i        = 1'b1;
                bus.in_sparsemap_i    = BUS'(sent);
                bus.in_nonzero_data_i = {8{BUS'(sent) ^ 32'hA5A5_0000}};
                wrQ.push_back('{chunk: sent / 4, beat: sent % 4, smap: BUS'(sent),
                                nz: {8{BUS'(sent) ^ 32'hA5A5_0000}}});
                sent++;
            end
            tick();
            cyc++;
        end
        bus.in_valid_i = 1'b0;
    endtask

    task automatic checkLoadDone(input string tag);
        checks++;
        if (bus.load_done_o !== 1'b1 || bus.loaded_o !== 1'b1 || bus.in_ready_o !== 1'b0 || wrQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL %s_done got done %0b loaded %0b ready %0b pending %0d exp 1 1 0 0",
                     tag, bus.load_done_o, bus.loaded_o, bus.in_ready_o, wrQ.size());
        end
        tick();
        checks++;
        if (bus.load_done_o !== 1'b0 || bus.mem_wr_dat_count_o !== '0 || bus.mem_wr_chunk_count_o !== '0) begin
            errors++;
            $display("[TB] FAIL %s_done_pulse got done %0b wr (%0d,%0d) exp 0 (0,0)", tag, bus.load_done_o,
                     bus.mem_wr_chunk_count_o, bus.mem_wr_dat_count_o);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.in_ready_o, bus.rd_valid_o, bus.rd_last_o, bus.load_done_o, bus.rd_done_o,
             bus.loaded_o, bus.mem_clr_o} !== 7'b0) begin
            errors++;
            $display("[TB] FAIL reset_outputs got %b exp 0000000", {bus.in_ready_o, bus.rd_valid_o, bus.rd_last_o,
                     bus.load_done_o, bus.rd_done_o, bus.loaded_o, bus.mem_clr_o});
        end
        checks++;
        if (bus.mem_wr_dat_count_o !== '0 || bus.mem_wr_chunk_count_o !== '0 ||
            bus.mem_rd_dat_count_o !== '0 || bus.mem_rd_chunk_count_o !== '0) begin
            errors++;
            $display("[TB] FAIL reset_counters got wr (%0d,%0d) rd (%0d,%0d) exp all 0",
                     bus.mem_wr_chunk_count_o, bus.mem_wr_dat_count_o,
                     bus.mem_rd_chunk_count_o, bus.mem_rd_dat_count_o);
        end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_load_back_to_back();
        applyStimulus(1'b1, 1'b0);
        driveBeats(1'b0);
        checkLoadDone("load_b2b");
    endtask

    task automatic test_load_gaps();
        applyStimulus(1'b1, 1'b0);
        checks++;
        if (bus.loaded_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reload_clears_loaded got %0b exp 0", bus.loaded_o);
        end
        driveBeats(1'b1);
        checkLoadDone("load_gap");
    endtask

    task automatic test_read();
        for (int i = 0; i < 16; i++) rdQ.push_back('{chunk: i / 4, beat: i % 4, last: (i == 15)});
        applyStimulus(1'b0, 1'b1);
        for (int c = 0; c < 16; c++) tick();
        checks++;
        if (bus.rd_done_o !== 1'b1 || bus.rd_valid_o !== 1'b0 || bus.loaded_o !== 1'b1 || rdQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL read_done got done %0b valid %0b loaded %0b pending %0d exp 1 0 1 0",
                     bus.rd_done_o, bus.rd_valid_o, bus.loaded_o, rdQ.size());
        end
        tick();
        checks++;
        if (bus.rd_done_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL read_done_pulse got %0b exp 0", bus.rd_done_o);
        end
    endtask

    task automatic test_stall();
        for (int i = 0; i < 16; i++) begin
            rdQ.push_back('{chunk: i / 4, beat: i % 4, last: (i == 15)});
            if (i == 6) begin
                rdQ.push_back('{chunk: 1, beat: 2, last: 1'b0});
                rdQ.push_back('{chunk: 1, beat: 2, last: 1'b0});
                rdQ.push_back('{chunk: 1, beat: 2, last: 1'b0});
            end
        end
        applyStimulus(1'b0, 1'b1);
        for (int c = 1; c <= 19; c++) begin
            bus.rd_stall_i = (c >= 7 && c <= 9);
            tick();
        end
        bus.rd_stall_i = 1'b0;
        checks++;
        if (bus.rd_done_o !== 1'b1 || rdQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL stall_done got done %0b pending %0d exp 1 0", bus.rd_done_o, rdQ.size());
        end
        tick();
    endtask

    task automatic test_reset_mid_load();
        applyStimulus(1'b1, 1'b0);
        waitReady();
        for (int i = 0; i < 7; i++) begin
            bus.in_valid_i        = 1'b1;
            bus.in_sparsemap_i    = BUS'(i);
            bus.in_nonzero_data_i = {8{BUS'(i) ^ 32'hA5A5_0000}};
            wrQ.push_back('{chunk: i / 4, beat: i % 4, smap: BUS'(i), nz: {8{BUS'(i) ^ 32'hA5A5_0000}}});
            tick();
        end
        bus.in_sparsemap_i = BUS'(7);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.in_ready_o !== 1'b0 || bus.loaded_o !== 1'b0 || bus.mem_wr_valid_o !== 1'b0 ||
            bus.mem_wr_dat_count_o !== '0 || bus.mem_wr_chunk_count_o !== '0 || wrQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL mid_load_reset got ready %0b loaded %0b wvalid %0b wr (%0d,%0d) pending %0d exp 0 0 0 (0,0) 0",
                     bus.in_ready_o, bus.loaded_o, bus.mem_wr_valid_o, bus.mem_wr_chunk_count_o,
                     bus.mem_wr_dat_count_o, wrQ.size());
        end
        bus.in_valid_i = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        applyStimulus(1'b0, 1'b1);
        for (int c = 0; c < 4; c++) begin
            checks++;
            if (bus.rd_valid_o !== 1'b0 || bus.loaded_o !== 1'b0) begin
                errors++;
                $display("[TB] FAIL rd_ignored_unloaded got valid %0b loaded %0b exp 0 0", bus.rd_valid_o, bus.loaded_o);
            end
            tick();
        end
    endtask

    task automatic test_clear_priority();
        applyStimulus(1'b1, 1'b0);
        driveBeats(1'b0);
        checkLoadDone("pre_clear");
        applyStimulus(1'b1, 1'b1);
`ifdef MEM_FILTER_CTRL_CLR_EN
        checks++;
        if (bus.mem_clr_o !== 1'b1 || bus.in_ready_o !== 1'b0 || bus.rd_valid_o !== 1'b0 || bus.loaded_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL clear_cycle got clr %0b ready %0b rvalid %0b loaded %0b exp 1 0 0 0",
                     bus.mem_clr_o, bus.in_ready_o, bus.rd_valid_o, bus.loaded_o);
        end
        tick();
`endif
        checks++;
        if (bus.mem_clr_o !== 1'b0 || bus.in_ready_o !== 1'b1 || bus.rd_valid_o !== 1'b0 || bus.loaded_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL load_after_start got clr %0b ready %0b rvalid %0b loaded %0b exp 0 1 0 0",
                     bus.mem_clr_o, bus.in_ready_o, bus.rd_valid_o, bus.loaded_o);
        end
        driveBeats(1'b0);
        checkLoadDone("post_clear");
    endtask

    initial begin
        bus.load_start_i      = 1'b0;
        bus.rd_start_i        = 1'b0;
        bus.rd_stall_i        = 1'b0;
        bus.in_valid_i        = 1'b0;
        bus.in_sparsemap_i    = '0;
        bus.in_nonzero_data_i = '0;
        test_reset();
        test_load_back_to_back();
        test_load_gaps();
        test_read();
        test_stall();
        test_reset_mid_load();
        test_clear_priority();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog got timeout exp completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/mem_filter_ctrl.md
Name: mem_filter_ctrl

Overview:
Sequencer for the filter SRAM bank (SRAM_FILTER_NUM chunks × WR_DAT_CYC_NUM bus beats).
- Accepts a valid/ready stream of sparsemap/nonzero beats and generates the memory write strobes and write chunk/beat indices.
- Replays the stored filters to the PE array as an ordered read sweep with stall support.
- Sits between the DMA/load front-end and the filter memory.

Parameters:
BUS_SIZE, 32, bits per sparsemap beat; bytes per nonzero-data beat
CHUNK_SIZE, 128, bits per filter chunk; must be a multiple of BUS_SIZE
SRAM_FILTER_NUM, 4, number of filter chunks held
WR_DAT_CYC_NUM, CHUNK_SIZE/BUS_SIZE (4), beats per chunk; derived, do not override

Ports:
clk_i  in  1  clock
rst_i  in  1  reset; asynchronous, active-low
load_start_i  in  1  pulse; begin a full bank load
in_sparsemap_i  in  BUS_SIZE  load-stream sparsemap beat
in_nonzero_data_i  in  BUS_SIZE×8  load-stream nonzero bytes
in_valid_i  in  1  load beat valid
in_ready_o  out  1  load beat accepted when valid&ready
mem_wr_sparsemap_o  out  BUS_SIZE  to memory; combinational pass-through of in_sparsemap_i
mem_wr_nonzero_data_o  out  BUS_SIZE×8  to memory; combinational pass-through of in_nonzero_data_i
mem_wr_valid_o  out  1  = in_valid_i & in_ready_o
mem_wr_dat_count_o  out  clog2(WR_DAT_CYC_NUM)  write beat index
mem_wr_chunk_count_o  out  clog2(SRAM_FILTER_NUM)  write chunk index
mem_clr_o  out  1  memory clear strobe (see Optional Feature)
rd_start_i  in  1  pulse; begin a read sweep
rd_stall_i  in  1  consumer stall; hold current read address
mem_rd_dat_count_o  out  clog2(WR_DAT_CYC_NUM)  read beat index
mem_rd_chunk_count_o  out  clog2(SRAM_FILTER_NUM)  read chunk index
rd_valid_o  out  1  memory read data at current indices is valid this cycle
rd_last_o  out  1  current read beat is the final beat of the sweep
load_done_o  out  1  one-cycle pulse after the final load beat
rd_done_o  out  1  one-cycle pulse after the final read beat is consumed
loaded_o  out  1  bank holds a complete filter set

Behaviour:
- Reset (rst_i low, asynchronous): state IDLE; all counters 0.
- Outputs low during reset: in_ready_o, rd_valid_o, rd_last_o, load_done_o, rd_done_o, loaded_o, mem_clr_o.
- States: IDLE, CLEAR (optional), LOAD, READY, READ.
- IDLE:
  - load_start_i → LOAD, or → CLEAR when the optional feature is enabled.
  - rd_start_i is ignored while loaded_o = 0.
- LOAD:
  - in_ready_o = 1.
  - Each accepted beat increments the beat counter. When the beat counter wraps from WR_DAT_CYC_NUM-1 to 0, the chunk counter increments.
  - Write indices are registered counters, valid in the same cycle as mem_wr_valid_o.
  - On acceptance at chunk = SRAM_FILTER_NUM-1 and beat = WR_DAT_CYC_NUM-1: next state READY, load_done_o pulses for the following cycle, loaded_o set, write counters cleared.
  - load_start_i and rd_start_i are ignored in LOAD.
  - An idle in_valid_i never advances the counters.
- READY:
  - in_ready_o = 0.
  - load_start_i → reload path: loaded_o cleared immediately, LOAD (or CLEAR).
  - rd_start_i → READ.
  - If both are asserted in the same cycle, load_start_i wins.
- READ:
  - Read indices start at 0,0. rd_valid_o = 1.
  - The address advances (beat-major, then chunk) on every cycle with rd_stall_i = 0. It holds while rd_stall_i = 1.
  - The memory read is combinational, so data at the indices is valid the same cycle; read latency is 0.
  - rd_last_o = 1 at chunk = SRAM_FILTER_NUM-1, beat = WR_DAT_CYC_NUM-1.
  - Last beat with no stall: rd_done_o pulses the next cycle, state returns to READY with read counters at 0, and loaded_o stays 1 so the bank can be re-read.
  - Starts are ignored in READ; a full sweep is SRAM_FILTER_NUM×WR_DAT_CYC_NUM non-stalled cycles.
- Counters are exactly clog2 wide. They wrap at the parameter bound, not at the power of two.
- Reset mid-LOAD or mid-READ: immediate IDLE with loaded_o = 0. Memory contents are not trusted until a fresh load.

Optional Feature:
MEM_FILTER_CTRL_CLR_EN
- Defined: load_start_i enters CLEAR for exactly one cycle, asserting mem_clr_o = 1 (drives the memory's synchronous clear), then goes to LOAD. in_ready_o = 0 during CLEAR.
- Undefined: no CLEAR state; load_start_i goes directly to LOAD; mem_clr_o is tied to 0.

Decomposition:
- Shared package mem_filter_pkg holds:
  - state enum mem_filter_ctrl_state_e: IDLE, CLEAR, LOAD, READY, READ;
  - localparams for the counter widths;
  - WR_DAT_CYC_NUM derivation.
- One sub-module, mem_filter_addr_cnt: a beat/chunk two-level counter with enable, clear and last flag. It is instantiated twice, once for write and once for read.

Test Plan:
1. Reset release, load_start_i, then 16 back-to-back beats with sparsemap = beat index:
   - mem_wr indices step (0,0)…(3,3);
   - load_done_o pulses on cycle 17;
   - loaded_o = 1.
2. Load with in_valid_i low on every other cycle: counters advance only on valid beats; 16 beats complete in 32 cycles.
3. rd_start_i after load, no stall: indices sweep (0,0)…(3,3) in 16 cycles; rd_last_o is asserted on cycle 16 only; rd_done_o pulses on cycle 17.
4. rd_stall_i high for 3 cycles at (1,2): indices hold at (1,2) with rd_valid_o = 1; the sweep completes in 19 cycles.
5. rst_i low at load beat 7: immediate IDLE, loaded_o = 0; a subsequent rd_start_i is ignored (rd_valid_o stays 0).
6. With MEM_FILTER_CTRL_CLR_EN defined, load_start_i and rd_start_i asserted together in READY: CLEAR is taken with a 1-cycle mem_clr_o, then LOAD, and no read occurs. Undefined: goes straight to LOAD and mem_clr_o is never asserted.
